// File: rtl/rank_order_filter_if.sv
// Sample-stream bundle for rank_order_filter.
//
// Signals:
//   DI    sample data, qualified by DSI
//   DSI   sample strobe
//   RANK  requested rank; 0 = maximum, N-1 = minimum
//   DO    registered result
//   DSO   one-cycle strobe; DO is valid in the same cycle
//   BUSY  high while the filter computes; DSI is ignored then
//   ERR   one-cycle strobe when a short frame is aborted
//
// Modports:
//   master  the sample source (drives DI/DSI/RANK)
//   slave   the filter (drives DO/DSO/BUSY/ERR)
interface rank_order_filter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 9,
    parameter int unsigned RW    = $clog2(N)
);
    logic [WIDTH-1:0] DI;
    logic             DSI;
    logic [RW-1:0]    RANK;
    logic [WIDTH-1:0] DO;
    logic             DSO;
    logic             BUSY;
    logic             ERR;

    modport master (
        output DI, DSI, RANK,
        input  DO, DSO, BUSY, ERR
    );

    modport slave (
        input  DI, DSI, RANK,
        output DO, DSO, BUSY, ERR
    );
endinterface

// File: rtl/rank_order_filter.sv
// Rank-order filter: captures a frame of N unsigned WIDTH-bit samples from a serial
// stream and returns the sample of a selected rank (0 = maximum, (N-1)/2 = median,
// N-1 = minimum). The result comes from repeated max-extraction over a register
// bank, one compare per cycle: each pass scans all N entries (N cycles) and then
// retires the winner (1 cycle); pass k yields the result.
//
// Ports:
//   CLK   clock, rising edge
//   nRST  asynchronous active-low reset
//   bus   rank_order_filter_if.slave (DI, DSI, RANK in; DO, DSO, BUSY, ERR out)
//
// Build option:
//   ROF_RANK_SEL_EN  defined: RANK is latched with the first sample of a frame and
//                    clamped to N-1. Undefined: RANK is ignored and the rank is
//                    fixed at (N-1)/2 (plain median filter).
module rank_order_filter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 9,
    parameter int unsigned RW    = $clog2(N)
) (
    input  logic               CLK,
    input  logic               nRST,
    rank_order_filter_if.slave bus
);

    localparam int unsigned CW = $clog2(N + 1);  // counters must reach N
    localparam int unsigned IW = $clog2(N);      // index into the register bank

    localparam logic [CW-1:0] LastCnt = CW'(N - 1);
    localparam logic [CW-1:0] NCnt    = CW'(N);

    typedef enum logic [1:0] {StIdle, StLoad, StCompute} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    scan_q;
    logic [CW-1:0]    pass_q;
    logic [WIDTH-1:0] max_q;
    logic [IW-1:0]    idx_q;
    logic             found_q;
    logic [N-1:0]     valid_q;
    logic [WIDTH-1:0] r_q [N];
    logic [WIDTH-1:0] do_q;
    logic             dso_q;
    logic             err_q;

    logic [CW-1:0]    k;  // rank in effect for the current frame

    // Decoded controls
    logic busy;
    logic capture;
    logic abort;
    logic last_sample;
    logic scan_active;
    logic pass_end;
    logic done;

    logic [IW-1:0] cnt_idx;
    logic [IW-1:0] scan_idx;

    assign cnt_idx  = cnt_q[IW-1:0];
    assign scan_idx = scan_q[IW-1:0];

    // ------------------------------------------------------------------
    // Rank selection
    // ------------------------------------------------------------------
`ifdef ROF_RANK_SEL_EN
    logic [CW-1:0] k_q;
    logic [CW-1:0] k_sel;

    always_comb begin
        k_sel = CW'(bus.RANK);
        if (32'(bus.RANK) > N - 1) begin
            k_sel = LastCnt;
        end
    end

    // Latched on the edge that captures the first sample of a frame.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            k_q <= '0;
        end else if (capture && (state_q == StIdle)) begin
            k_q <= k_sel;
        end
    end

    assign k = k_q;
`else
    logic unused_rank;

    assign unused_rank = ^bus.RANK;
    assign k           = CW'((N - 1) / 2);
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.DSI) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (!bus.DSI) begin
                    state_d = StIdle;
                end else if (cnt_q == LastCnt) begin
                    state_d = StCompute;
                end
            end
            StCompute: begin
                if ((scan_q == NCnt) && (pass_q == k)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs / datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        busy        = 1'b0;
        capture     = 1'b0;
        abort       = 1'b0;
        last_sample = 1'b0;
        scan_active = 1'b0;
        pass_end    = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            StIdle: begin
                capture = bus.DSI;
            end
            StLoad: begin
                capture     = bus.DSI;
                abort       = !bus.DSI;
                last_sample = bus.DSI && (cnt_q == LastCnt);
            end
            StCompute: begin
                busy        = 1'b1;
                scan_active = (scan_q != NCnt);
                pass_end    = (scan_q == NCnt);
                done        = (scan_q == NCnt) && (pass_q == k);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Sample bank (data only, no reset needed; validity lives in valid_q)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (capture) begin
            r_q[cnt_idx] <= bus.DI;
        end
    end

    // ------------------------------------------------------------------
    // Counters, max-extraction and result
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q   <= '0;
            scan_q  <= '0;
            pass_q  <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            found_q <= 1'b0;
            valid_q <= '0;
            do_q    <= '0;
            dso_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            dso_q <= 1'b0;
            err_q <= 1'b0;

            if (capture) begin
                if (last_sample) begin
                    cnt_q   <= '0;
                    valid_q <= '1;
                    pass_q  <= '0;
                    scan_q  <= '0;
                    found_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            if (abort) begin
                cnt_q <= '0;
                err_q <= 1'b1;
            end

            if (scan_active) begin
                // Strictly greater only: on ties the lowest index keeps the win.
                if (valid_q[scan_idx] && (!found_q || (r_q[scan_idx] > max_q))) begin
                    max_q   <= r_q[scan_idx];
                    idx_q   <= scan_idx;
                    found_q <= 1'b1;
                end
                scan_q <= scan_q + 1'b1;
            end

            if (pass_end) begin
                valid_q[idx_q] <= 1'b0;
                if (done) begin
                    do_q  <= max_q;
                    dso_q <= 1'b1;
                end else begin
                    pass_q  <= pass_q + 1'b1;
                    scan_q  <= '0;
                    found_q <= 1'b0;
                end
            end
        end
    end

    assign bus.DO   = do_q;
    assign bus.DSO  = dso_q;
    assign bus.BUSY = busy;
    assign bus.ERR  = err_q;

endmodule

// File: tb/tb_rank_order_filter.sv
module tb_rank_order_filter;

    localparam int N = 9;
    localparam int W = 8;

    logic clk = 1'b0;
    logic nrst;

    always #5 clk = ~clk;

    rank_order_filter_if #(.WIDTH(W), .N(N)) bus ();

    rank_order_filter #(.WIDTH(W), .N(N)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_do;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Rank actually used by the filter for a requested RANK.
    function automatic int model_k(input int rank);
`ifdef ROF_RANK_SEL_EN
        return (rank > N - 1) ? N - 1 : rank;
`else
        return (N - 1) / 2;
`endif
    endfunction

    // (k+1)-th largest of the multiset.
    function automatic int model_val(input int s[N], input int k);
        int q[$];
        foreach (s[i]) q.push_back(s[i]);
        q.rsort();
        return q[k];
    endfunction

    // Starts at a negedge where the first sample may be driven; returns at the
    // negedge of the DSO cycle (or after a time-out) with DSI low.
    task automatic run_frame(input string tag, input int s[N], input int rank,
                             input int extra);
        int k;
        int exp;
        int lat;
        bit busy_ok;
        k   = model_k(rank);
        exp = model_val(s, k);
        for (int i = 0; i < N; i++) begin
            if (i == 1) check({tag, "_dso_prev_low"}, 32'(bus.DSO), 32'd0);
            bus.DSI  = 1'b1;
            bus.DI   = 8'(s[i]);
            bus.RANK = 4'(rank);
            @(negedge clk);
        end
        lat     = 0;
        busy_ok = 1'b1;
        while (!bus.DSO && lat <= 300) begin
            if (!bus.BUSY) busy_ok = 1'b0;
            bus.DSI = (lat < extra);
            bus.DI  = 8'($urandom);
            lat++;
            @(negedge clk);
        end
        bus.DSI = 1'b0;
        check({tag, "_latency"}, 32'(lat), 32'((k + 1) * (N + 1)));
        check({tag, "_do"}, 32'(bus.DO), 32'(exp));
        check({tag, "_busy"}, {30'd0, busy_ok, bus.BUSY}, 32'b10);
        last_do = 8'(exp);
    endtask

    task automatic dso_dropped(input string tag);
        @(negedge clk);
        check({tag, "_dso_one_cycle"}, 32'(bus.DSO), 32'd0);
    endtask

    int s[N];
    int dso_seen;

    initial begin
        nrst     = 1'b0;
        bus.DSI  = 1'b0;
        bus.DI   = '0;
        bus.RANK = '0;
        last_do  = '0;
        repeat (2) @(negedge clk);
        check("rst_do", 32'(bus.DO), 32'd0);
        check("rst_dso", 32'(bus.DSO), 32'd0);
        check("rst_busy", 32'(bus.BUSY), 32'd0);
        check("rst_err", 32'(bus.ERR), 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        // Basic frame across several ranks
        s = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
        run_frame("median", s, 4, 0);
        dso_dropped("median");
        run_frame("rank0", s, 0, 0);
        dso_dropped("rank0");
        run_frame("rank8", s, 8, 0);
        dso_dropped("rank8");
        run_frame("rank15", s, 15, 0);
        dso_dropped("rank15");

        // Extremes and duplicates
        s = '{255, 255, 255, 0, 255, 255, 255, 255, 255};
        run_frame("allff", s, 4, 0);
        dso_dropped("allff");
        s = '{16, 16, 32, 32, 32, 32, 32, 32, 32};
        run_frame("dups", s, 8, 0);
        dso_dropped("dups");

        // Short frame abort
        for (int i = 0; i < 5; i++) begin
            bus.DSI = 1'b1;
            bus.DI  = 8'($urandom);
            @(negedge clk);
        end
        bus.DSI = 1'b0;
        @(negedge clk);
        check("short_err", 32'(bus.ERR), 32'd1);
        check("short_dso", 32'(bus.DSO), 32'd0);
        check("short_do_kept", 32'(bus.DO), 32'(last_do));
        @(negedge clk);
        check("short_err_pulse", 32'(bus.ERR), 32'd0);
        s = '{3, 200, 17, 17, 90, 4, 250, 61, 100};
        run_frame("after_short", s, 4, 0);
        dso_dropped("after_short");

        // DSI held 14 cycles, then a frame chained into the DSO cycle
        s = '{40, 10, 70, 20, 90, 30, 60, 50, 80};
        run_frame("held", s, 4, 5);
        s = '{5, 6, 7, 1, 2, 3, 9, 8, 4};
        run_frame("chained", s, 2, 0);
        dso_dropped("chained");

        // Random frames with small value range for duplicates
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) s[i] = int'($urandom_range(0, 15));
            run_frame($sformatf("rand%0d", r), s, int'($urandom_range(0, 15)), 0);
            dso_dropped($sformatf("rand%0d", r));
        end

        // Reset during pass 2
        s = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
        for (int i = 0; i < N; i++) begin
            bus.DSI  = 1'b1;
            bus.DI   = 8'(s[i]);
            bus.RANK = 4'd4;
            @(negedge clk);
        end
        bus.DSI = 1'b0;
        repeat (2 * (N + 1) + 4) @(negedge clk);
        check("pre_rst_busy", 32'(bus.BUSY), 32'd1);
        nrst = 1'b0;
        #1;
        check("midrst_do", 32'(bus.DO), 32'd0);
        check("midrst_dso", 32'(bus.DSO), 32'd0);
        check("midrst_busy", 32'(bus.BUSY), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        dso_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.DSO) dso_seen++;
        end
        check("midrst_no_dso", 32'(dso_seen), 32'd0);
        s = '{12, 250, 33, 0, 77, 77, 140, 200, 5};
        run_frame("after_rst", s, 4, 0);
        dso_dropped("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rank_order_filter.md
Name: rank_order_filter

Overview:
- Parametrised successor to the fixed 9-tap median block. Captures a frame of N unsigned WIDTH-bit samples from a serial stream, then returns the sample of a selectable rank.
- Rank 0 is the maximum, rank (N-1)/2 the median, rank N-1 the minimum.
- The result is computed by repeated max-extraction over an internal register bank, one compare per cycle.
- Sits in the pixel/sample filtering path; a drop-in replacement for the median stage, with BUSY and ERR added.

Parameters:
- WIDTH, 8, sample width in bits; all comparisons are unsigned.
- N, 9, samples per frame; N >= 3, any integer.
- RW, $clog2(N), width of the RANK port.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- DI  input  WIDTH  sample data, qualified by DSI.
- DSI  input  1  sample strobe; DI is captured on every rising CLK edge where DSI=1 and state is IDLE or LOAD.
- RANK  input  RW  requested rank, sampled on the edge that captures the first sample of a frame.
- DO  output  WIDTH  result, registered; holds its value until the next result.
- DSO  output  1  one-cycle pulse; DO is valid in the same cycle.
- BUSY  output  1  high in COMPUTE; DSI is ignored while BUSY=1.
- ERR  output  1  one-cycle pulse when a short frame is aborted.

Behaviour:
- Reset (asynchronous, nRST low): DO=0, DSO=0, BUSY=0, ERR=0, state=IDLE, sample count=0, all valid bits cleared. Reset mid-LOAD or mid-COMPUTE discards the frame with no DSO.
- IDLE -> LOAD:
  - Taken on the first edge with DSI=1.
  - That edge writes DI to R[0], sets cnt=1 and latches rank k = min(RANK, N-1).
- LOAD:
  - Each edge with DSI=1 writes R[cnt] and increments cnt.
  - When the Nth sample is written (cnt reaches N): go to COMPUTE, set BUSY=1, set all N valid bits, set pass=0.
  - DSI=0 while 0 < cnt < N: abort, pulse ERR for one cycle, return to IDLE, DO unchanged.
  - Gaps are not allowed; a frame must be N consecutive DSI=1 cycles.
- COMPUTE, pass p = 0..k, each pass N+1 cycles:
  - Scan cycles 0..N-1: compare R[i] against the running max, valid entries only.
  - Only a strictly greater value replaces the running max, so on ties the lowest index wins.
  - Cycle N: clear the valid bit of the winning index and advance pass.
- Completion:
  - At the end of pass k, DO <= max found in that pass, DSO=1 for one cycle, BUSY=0, state -> IDLE.
- Latency: take the edge that captures the Nth sample as edge 0. DSO is high in the cycle following edge (k+1)*(N+1).
- Samples with DSI=1 while BUSY=1 are dropped silently. No backpressure.
- DSI=1 in the DSO cycle starts a new frame (IDLE-equivalent); no dead cycle is required.
- Duplicates are counted individually: rank k is the (k+1)-th largest of the multiset.
- Counters (cnt, scan index, pass) are sized $clog2(N+1) bits; no wrap occurs within a frame.

Optional Feature:
- Macro: ROF_RANK_SEL_EN.
- Defined: RANK is sampled as above; out-of-range values are clamped to N-1.
- Undefined: the RANK port is present but ignored, and k is fixed at (N-1)/2, integer division. The block then behaves as a plain median filter; for N=9 the latency is 5*10 = 50 cycles.

Test Plan:
1. N=9, RANK=4, samples 9,1,8,2,7,3,6,4,5 on 9 consecutive DSI cycles -> DO=5, DSO high exactly one cycle, 50 edges after the last sample; BUSY high throughout COMPUTE.
2. Same frame with RANK=0 -> DO=9 after 10 edges. RANK=8 -> DO=1 after 90 edges. RANK=15 (macro on) -> clamped, DO=1.
3. All samples 0xFF except one 0x00, RANK=4 -> DO=0xFF. Then a frame of 0x10,0x10,0x20 x7, RANK=8 -> DO=0x10 (duplicates counted).
4. DSI high 5 cycles then low -> ERR one-cycle pulse, no DSO, DO keeps its previous value. An immediately following full frame gives the correct median.
5. DSI held high 14 cycles -> first 9 samples used, last 5 dropped while BUSY=1. Result matches the first-9 median. A new frame started in the DSO cycle completes correctly.
6. nRST pulsed low during pass 2 -> DO=0, DSO=0, BUSY=0 immediately. The next frame produces the correct result with the nominal latency.
